// File: rtl/ms_job_sched_if.sv
// Bundle of all scheduler-facing signals except clock and reset.
//   master : the scheduler (drives grants, core stimulus and host-side results)
//   slave  : the environment (host requesters plus the shared maze-solver core)
// Requester side : req, grant, src_valid, src_maze, dst_*, done, done_status, path_len
// Core side      : core_in_valid, core_maze, core_clr, core_out_valid, core_nv, core_x, core_y
interface ms_job_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] src_valid;
  logic [NREQ-1:0] src_maze;

  logic            core_in_valid;
  logic            core_maze;
  logic            core_clr;
  logic            core_out_valid;
  logic            core_nv;
  logic [3:0]      core_x;
  logic [3:0]      core_y;

  logic            dst_valid;
  logic [3:0]      dst_x;
  logic [3:0]      dst_y;
  logic [IDW-1:0]  dst_id;
  logic            done;
  logic [1:0]      done_status;
  logic [8:0]      path_len;

  modport master (
    input  req, src_valid, src_maze, core_out_valid, core_nv, core_x, core_y,
    output grant, core_in_valid, core_maze, core_clr,
    output dst_valid, dst_x, dst_y, dst_id, done, done_status, path_len
  );

  modport slave (
    output req, src_valid, src_maze, core_out_valid, core_nv, core_x, core_y,
    input  grant, core_in_valid, core_maze, core_clr,
    input  dst_valid, dst_x, dst_y, dst_id, done, done_status, path_len
  );
endinterface

// File: rtl/ms_job_sched.sv
// Round-robin scheduler sharing one serial-in maze-solver core among NREQ requesters.
// A granted requester streams MAZE_BITS maze bits into the core; the core's path
// coordinates (or its no-path verdict) come back tagged with the requester id, and the
// job closes with a one-cycle done pulse carrying status and path length. A broken
// stream or a silent core is recovered with a two-cycle core clear.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name (rst_n = 1 resets)
//   bus   : ms_job_sched_if.master (requester ports, core ports, results)
// done_status: 00 OK, 01 NOPATH, 10 TIMEOUT, 11 ABORT.
module ms_job_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAZE_BITS = 289,
  parameter int unsigned TIMEOUT   = 4096
) (
  input logic            clk,
  input logic            rst_n,
  ms_job_sched_if.master bus
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BCW = $clog2(MAZE_BITS);
  localparam int unsigned TW  = $clog2(TIMEOUT);

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatNoPath  = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;
  localparam logic [1:0] StatAbort   = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StOut, StClr, StDone} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [8:0]      plen_q, plen_d;
  logic            clr_cnt_q, clr_cnt_d;
  logic [1:0]      status_q, status_d;
  logic            in_v_q, in_v_d;
  logic            in_m_q, in_m_d;
  logic            dst_v_q, dst_v_d;
  logic [3:0]      dst_x_q, dst_x_d;
  logic [3:0]      dst_y_q, dst_y_d;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic            src_v_sel;
  logic            src_m_sel;

  // Only the grantee's lane is ever looked at, so other lanes cannot leak into the core.
  assign src_v_sel = bus.src_valid[owner_q];
  assign src_m_sel = bus.src_maze[owner_q];

  // First requester at or after the rr pointer, wrapping.
  always_comb begin : p_arb
    int unsigned    cand;
    logic [IDW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand     = (32'(rr_q) + i) % NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin : p_next
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    plen_d    = plen_q;
    clr_cnt_d = clr_cnt_q;
    status_d  = status_q;
    in_v_d    = 1'b0;
    in_m_d    = 1'b0;
    dst_v_d   = 1'b0;
    dst_x_d   = 4'd0;
    dst_y_d   = 4'd0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d   = StLoad;
          grant_d   = NREQ'(1'b1) << win_idx;
          owner_d   = win_idx;
          rr_d      = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IDW'(1);
          bit_cnt_d = '0;
          tmr_d     = '0;
          plen_d    = '0;
          clr_cnt_d = 1'b0;
          status_d  = StatOk;
        end
      end

      StLoad: begin
        in_v_d = src_v_sel;
        in_m_d = src_v_sel & src_m_sel;
        if (src_v_sel) begin
          if (bit_cnt_q == BCW'(MAZE_BITS - 1)) begin
            state_d = StWait;
            tmr_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else if (bit_cnt_q != '0) begin
          // Stream broke after it started.
          state_d   = StClr;
          status_d  = StatAbort;
          clr_cnt_d = 1'b0;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d   = StClr;
          status_d  = StatTimeout;
          clr_cnt_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      StWait: begin
        // The no-path verdict wins over a simultaneous coordinate.
        if (bus.core_nv) begin
          state_d  = StDone;
          status_d = StatNoPath;
        end else if (bus.core_out_valid) begin
          state_d = StOut;
          dst_v_d = 1'b1;
          dst_x_d = bus.core_x;
          dst_y_d = bus.core_y;
          plen_d  = 9'd1;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d   = StClr;
          status_d  = StatTimeout;
          clr_cnt_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      StOut: begin
        if (bus.core_out_valid) begin
          dst_v_d = 1'b1;
          dst_x_d = bus.core_x;
          dst_y_d = bus.core_y;
          if (plen_q != 9'd511) begin
            plen_d = plen_q + 9'd1;
          end
        end else begin
          state_d  = StDone;
          status_d = StatOk;
        end
      end

      StClr: begin
        if (clr_cnt_q) begin
          state_d = StDone;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Grant is released in the same cycle that done is presented.
    if (state_d == StDone) begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      plen_q    <= '0;
      clr_cnt_q <= 1'b0;
      status_q  <= 2'b00;
      in_v_q    <= 1'b0;
      in_m_q    <= 1'b0;
      dst_v_q   <= 1'b0;
      dst_x_q   <= 4'd0;
      dst_y_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      plen_q    <= plen_d;
      clr_cnt_q <= clr_cnt_d;
      status_q  <= status_d;
      in_v_q    <= in_v_d;
      in_m_q    <= in_m_d;
      dst_v_q   <= dst_v_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.core_in_valid = in_v_q;
  assign bus.core_maze     = in_m_q;
  assign bus.core_clr      = (state_q == StClr);
  assign bus.dst_valid     = dst_v_q;
  assign bus.dst_x         = dst_x_q;
  assign bus.dst_y         = dst_y_q;
  assign bus.dst_id        = owner_q;
  assign bus.done          = (state_q == StDone);
  assign bus.done_status   = status_q;
  assign bus.path_len      = plen_q;

endmodule

// File: tb/tb_ms_job_sched.sv
module tb_ms_job_sched;
  localparam int NREQ      = 4;
  localparam int MAZE_BITS = 289;
  localparam int TIMEOUT   = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ms_job_sched_if #(.NREQ(NREQ)) bus ();

  ms_job_sched #(
    .NREQ     (NREQ),
    .MAZE_BITS(MAZE_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: round-robin pointer as the spec defines it.
  int m_rr = 0;

  // Observations gathered by the monitor.
  int         cyc = 0;
  int         ndone;
  int         done_cyc;
  logic [1:0] d_status;
  int         d_len;
  int         d_id;
  int         clr_cnt;
  int         multi_grant = 0;
  logic [7:0] dst_q[$];
  int         dstid_q[$];
  logic       core_q[$];

  // Stimulus-side expectations.
  logic [7:0] exp_q[$];
  logic       sent_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (bus.dst_valid) begin
        dst_q.push_back({bus.dst_x, bus.dst_y});
        dstid_q.push_back(int'(bus.dst_id));
      end
      if (bus.core_in_valid) core_q.push_back(bus.core_maze);
      if (bus.core_clr) clr_cnt++;
      if ($countones(bus.grant) > 1) multi_grant++;
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
        d_status = bus.done_status;
        d_len    = int'(bus.path_len);
        d_id     = int'(bus.dst_id);
      end
    end
  end

  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] e;
    e    = '0;
    e[w] = 1'b1;
    return e;
  endfunction

  task automatic clear_obs();
    ndone   = 0;
    clr_cnt = 0;
    d_len   = -1;
    d_id    = -1;
    d_status = 2'bxx;
    dst_q.delete();
    dstid_q.delete();
    core_q.delete();
    exp_q.delete();
    sent_q.delete();
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output int gcyc, output bit ok);
    ok   = 1'b0;
    g    = '0;
    gcyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.grant != '0) begin
        g    = bus.grant;
        gcyc = cyc;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  // Grantee lane carries the maze; the other lanes carry random noise.
  task automatic load_stream(input int id, input int nbits);
    logic b;
    for (int k = 0; k < nbits; k++) begin
      b = 1'($urandom_range(0, 1));
      bus.src_valid     = NREQ'($urandom);
      bus.src_maze      = NREQ'($urandom);
      bus.src_valid[id] = 1'b1;
      bus.src_maze[id]  = b;
      sent_q.push_back(b);
      @(posedge clk); #1;
    end
    bus.src_valid = '0;
    bus.src_maze  = '0;
  endtask

  task automatic core_emit(input int n);
    logic [7:0] c;
    for (int d = 0; d < int'($urandom_range(1, 4)); d++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < n; k++) begin
      c = 8'($urandom);
      bus.core_out_valid = 1'b1;
      bus.core_x = c[7:4];
      bus.core_y = c[3:0];
      exp_q.push_back(c);
      @(posedge clk); #1;
    end
    bus.core_out_valid = 1'b0;
    bus.core_x = 4'd0;
    bus.core_y = 4'd0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ndone > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus.grant); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if ({bus.core_in_valid, bus.core_maze, bus.core_clr} !== 3'b000) begin
      failures++; $display("FAIL reset_core got=%b exp=000", {bus.core_in_valid, bus.core_maze, bus.core_clr});
    end
    checks++; if ({bus.dst_valid, bus.dst_x, bus.dst_y, bus.dst_id} !== '0) begin
      failures++; $display("FAIL reset_dst got=%b exp=0", {bus.dst_valid, bus.dst_x, bus.dst_y, bus.dst_id});
    end
    checks++; if ({bus.done_status, bus.path_len} !== '0) begin
      failures++; $display("FAIL reset_status got=%b exp=0", {bus.done_status, bus.path_len});
    end
    rst_n = 1'b0;
    m_rr  = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.grant !== '0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL idle_no_req got=%b/%b exp=0/0", bus.grant, bus.done);
    end
  endtask

  task automatic test_single_job();
    logic [NREQ-1:0] g; int gc; bit ok; int w; int nbad; int nbits_bad; int nid_bad;
    clear_obs();
    bus.req = 4'b0001;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL single_grant got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    load_stream(w, MAZE_BITS);
    core_emit(33);
    wait_done(50, ok);
    bus.req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL single_done got=none exp=pulse"); end
    checks++; if (d_status !== 2'b00) begin failures++; $display("FAIL single_status got=%b exp=00", d_status); end
    checks++; if (d_len != 33) begin failures++; $display("FAIL single_len got=%0d exp=33", d_len); end
    checks++; if (d_id != w) begin failures++; $display("FAIL single_id got=%0d exp=%0d", d_id, w); end
    nbad = 0;
    for (int k = 0; k < exp_q.size() && k < dst_q.size(); k++) if (dst_q[k] !== exp_q[k]) nbad++;
    checks++; if (dst_q.size() != 33 || nbad != 0) begin
      failures++; $display("FAIL single_coords got=%0d/%0d_bad exp=33/0", dst_q.size(), nbad);
    end
    nid_bad = 0;
    foreach (dstid_q[k]) if (dstid_q[k] != w) nid_bad++;
    checks++; if (nid_bad != 0) begin failures++; $display("FAIL single_dst_id got=%0d_bad exp=0", nid_bad); end
    nbits_bad = 0;
    for (int k = 0; k < sent_q.size() && k < core_q.size(); k++) if (core_q[k] !== sent_q[k]) nbits_bad++;
    checks++; if (core_q.size() != MAZE_BITS || nbits_bad != 0) begin
      failures++; $display("FAIL single_maze got=%0d/%0d_bad exp=%0d/0", core_q.size(), nbits_bad, MAZE_BITS);
    end
    @(posedge clk); #1;
    checks++; if (ndone != 1 || bus.grant !== '0) begin
      failures++; $display("FAIL single_pulse got=%0d/%b exp=1/0", ndone, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g; int gc; bit ok; int w; int n; int prev_done; int nbad;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_rr  = 0;
    prev_done = 0;
    bus.req = '1;
    for (int j = 0; j < 5; j++) begin
      clear_obs();
      w = pick(bus.req);
      wait_grant(g, gc, ok);
      checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", j, g, onehot(w)); end
      if (j > 0) begin
        checks++; if (gc - prev_done != 2) begin
          failures++; $display("FAIL rr_gap%0d got=%0d exp=2", j, gc - prev_done);
        end
      end
      m_rr = (w + 1) % NREQ;
      n = $urandom_range(1, 40);
      load_stream(w, MAZE_BITS);
      core_emit(n);
      wait_done(50, ok);
      nbad = 0;
      for (int k = 0; k < exp_q.size() && k < dst_q.size(); k++) if (dst_q[k] !== exp_q[k]) nbad++;
      checks++; if (!ok || d_status !== 2'b00 || d_len != n || d_id != w) begin
        failures++; $display("FAIL rr_done%0d got=%0d/%b/%0d/%0d exp=1/00/%0d/%0d", j, ok, d_status, d_len, d_id, n, w);
      end
      checks++; if (dst_q.size() != n || nbad != 0) begin
        failures++; $display("FAIL rr_coords%0d got=%0d/%0d_bad exp=%0d/0", j, dst_q.size(), nbad, n);
      end
      prev_done = done_cyc;
    end
    bus.req = '0;
    @(posedge clk); #1;
    checks++; if (multi_grant != 0) begin failures++; $display("FAIL rr_onehot got=%0d exp=0", multi_grant); end
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] g; int gc; bit ok; int w;
    clear_obs();
    bus.req = 4'b0100;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL abort_grant got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    load_stream(w, 101);
    wait_done(20, ok);
    bus.req = '0;
    checks++; if (!ok || d_status !== 2'b11 || d_id != 2) begin
      failures++; $display("FAIL abort_done got=%0d/%b/%0d exp=1/11/2", ok, d_status, d_id);
    end
    checks++; if (clr_cnt != 2) begin failures++; $display("FAIL abort_clr got=%0d exp=2", clr_cnt); end
    checks++; if (core_q.size() != 101) begin failures++; $display("FAIL abort_in_valid got=%0d exp=101", core_q.size()); end
    checks++; if (dst_q.size() != 0) begin failures++; $display("FAIL abort_dst got=%0d exp=0", dst_q.size()); end
  endtask

  task automatic test_wait_timeout();
    logic [NREQ-1:0] g; int gc; bit ok; int w; int wc;
    clear_obs();
    bus.req = 4'b1000;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL wto_grant got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    load_stream(w, MAZE_BITS);
    wc = cyc;
    wait_done(TIMEOUT + 50, ok);
    bus.req = '0;
    checks++; if (!ok || d_status !== 2'b10 || d_len != 0 || d_id != 3) begin
      failures++; $display("FAIL wto_done got=%0d/%b/%0d/%0d exp=1/10/0/3", ok, d_status, d_len, d_id);
    end
    checks++; if (clr_cnt != 2) begin failures++; $display("FAIL wto_clr got=%0d exp=2", clr_cnt); end
    checks++; if (done_cyc - wc < TIMEOUT || done_cyc - wc > TIMEOUT + 4) begin
      failures++; $display("FAIL wto_latency got=%0d exp=%0d..%0d", done_cyc - wc, TIMEOUT, TIMEOUT + 4);
    end
  endtask

  task automatic test_load_timeout();
    logic [NREQ-1:0] g; int gc; bit ok; int w;
    clear_obs();
    bus.req = 4'b0010;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL lto_grant got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    wait_done(TIMEOUT + 50, ok);
    bus.req = '0;
    checks++; if (!ok || d_status !== 2'b10 || d_len != 0 || d_id != 1) begin
      failures++; $display("FAIL lto_done got=%0d/%b/%0d/%0d exp=1/10/0/1", ok, d_status, d_len, d_id);
    end
    checks++; if (clr_cnt != 2 || core_q.size() != 0) begin
      failures++; $display("FAIL lto_clr got=%0d/%0d exp=2/0", clr_cnt, core_q.size());
    end
    checks++; if (done_cyc - gc < TIMEOUT || done_cyc - gc > TIMEOUT + 4) begin
      failures++; $display("FAIL lto_latency got=%0d exp=%0d..%0d", done_cyc - gc, TIMEOUT, TIMEOUT + 4);
    end
  endtask

  task automatic test_nopath();
    logic [NREQ-1:0] g; int gc; bit ok; int w;
    clear_obs();
    bus.req = 4'b0001;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL nopath_grant got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    bus.req = '0;  // grantee withdraws; the job must still complete
    load_stream(w, MAZE_BITS);
    @(posedge clk); #1;
    bus.core_out_valid = 1'b1;
    bus.core_nv        = 1'b1;
    bus.core_x         = 4'($urandom);
    bus.core_y         = 4'($urandom);
    @(posedge clk); #1;
    bus.core_out_valid = 1'b0;
    bus.core_nv        = 1'b0;
    wait_done(20, ok);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (!ok || d_status !== 2'b01 || d_len != 0 || d_id != w) begin
      failures++; $display("FAIL nopath_done got=%0d/%b/%0d/%0d exp=1/01/0/%0d", ok, d_status, d_len, d_id, w);
    end
    checks++; if (dst_q.size() != 0) begin failures++; $display("FAIL nopath_dst got=%0d exp=0", dst_q.size()); end
  endtask

  task automatic test_reset_mid_out();
    logic [NREQ-1:0] g; int gc; bit ok; int w; int nd;
    clear_obs();
    bus.req = 4'b0011;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL rst_grant1 got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    load_stream(w, MAZE_BITS);
    for (int k = 0; k < 10; k++) begin
      bus.core_out_valid = 1'b1;
      bus.core_x = 4'($urandom);
      bus.core_y = 4'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.grant, bus.dst_valid, bus.done, bus.core_clr} !== '0) begin
      failures++; $display("FAIL rst_async got=%b exp=0", {bus.grant, bus.dst_valid, bus.done, bus.core_clr});
    end
    bus.core_out_valid = 1'b0;
    nd = ndone;
    m_rr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    w = pick(bus.req);
    wait_grant(g, gc, ok);
    checks++; if (ndone != nd) begin failures++; $display("FAIL rst_no_done got=%0d exp=%0d", ndone, nd); end
    checks++; if (!ok || g !== onehot(w)) begin failures++; $display("FAIL rst_grant2 got=%b exp=%b", g, onehot(w)); end
    m_rr = (w + 1) % NREQ;
    clear_obs();
    load_stream(w, MAZE_BITS);
    core_emit(5);
    wait_done(50, ok);
    bus.req = '0;
    checks++; if (!ok || d_status !== 2'b00 || d_len != 5 || d_id != w) begin
      failures++; $display("FAIL rst_job got=%0d/%b/%0d/%0d exp=1/00/5/%0d", ok, d_status, d_len, d_id, w);
    end
  endtask

  initial begin
    rst_n              = 1'b1;
    bus.req            = '0;
    bus.src_valid      = '0;
    bus.src_maze       = '0;
    bus.core_out_valid = 1'b0;
    bus.core_nv        = 1'b0;
    bus.core_x         = 4'd0;
    bus.core_y         = 4'd0;
    ndone              = 0;
    clr_cnt            = 0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_abort();
    test_wait_timeout();
    test_load_timeout();
    test_nopath();
    test_reset_mid_out();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
